link_sensores_arq: RTL and testbench

Parametrised sensor acquisition link. Scans N sensor channels round-robin and builds a framed packet {parity, address, data} per sample. Passes each packet over an internal registered link and checks parity on the receive side. On a parity failure, retransmits the same latched packet up to a bounded number of times. Verified data is demultiplexed into a per-channel output register bank. Sits between the raw sensor inputs and downstream consumers as the next-generation acquisition front end with retransmission.

---
 rtl/sensores_pkg.sv | 40 ++++
 rtl/verificador_paridade_param.sv | 20 ++
 rtl/link_sensores_arq.sv | 180 ++++++++++++++++++
 tb/tb_link_sensores_arq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensores_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensores_pkg
// Description : Shared definitions for the sensor acquisition link.
//               - FSM state encoding (OCIOSO, ENVIA, VERIFICA)
//               - failure counter width and saturation value
//               - packet field-offset helpers
// Revision    : 1.0 - initial release
// ============================================================================
package sensores_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENVIA    = 2'd1,
        VERIFICA = 2'd2
    } estado_t;

    localparam int LARGURA_FALHAS = 8;
    localparam logic [LARGURA_FALHAS-1:0] FALHAS_SATURADO = 8'd255;

    // Address width: at least one bit even for tiny channel counts.
    function automatic int bits_endereco(input int n_canais);
        return (n_canais > 2) ? $clog2(n_canais) : 1;
    endfunction

    // Packet layout, MSB to LSB: {parity, address, data}.
    function automatic int largura_pacote(input int a, input int largura);
        return 1 + a + largura;
    endfunction

    function automatic int pos_paridade(input int a, input int largura);
        return a + largura;
    endfunction

    function automatic int lsb_endereco(input int largura);
        return largura;
    endfunction

endpackage
`default_nettype wire

// File: rtl/verificador_paridade_param.sv
`default_nettype none
// ============================================================================
// Module      : verificador_paridade_param
// Description : Receive-side parity checker. A packet carries even parity
//               over all of its bits, so any nonzero XOR is an error.
// Ports       : pacote [P-1:0] in  - captured packet
//               erro          out - 1 when the packet parity is odd
// Revision    : 1.0 - initial release
// ============================================================================
module verificador_paridade_param #(
    parameter int P = 12
) (
    input  logic [P-1:0] pacote,
    output logic         erro
);

    assign erro = ^pacote;

endmodule
`default_nettype wire

// File: rtl/link_sensores_arq.sv
`default_nettype none
// ============================================================================
// Module      : link_sensores_arq
// Description : Round-robin sensor acquisition link with parity-checked
//               internal transfer and bounded retransmission.
//               Build option: SENSORES_RETX_EN enables retransmission; when
//               undefined a bad packet is dropped immediately.
// Ports       : clk, rst (sync, active high)
//               sensores          in  flat channel inputs
//               habilita          in  start a transaction (sampled in OCIOSO)
//               erro_injetado     in  flips packet bit 0 on link capture
//               pacote            out latched packet {parity, addr, data}
//               pacote_valido     out high during ENVIA
//               solicitar_reenvio out pulse on parity failure
//               saidas            out verified per-channel data bank
//               atualizado        out one-hot write strobe for saidas
//               canal_ativo       out current/next channel
//               falhas            out saturating dropped-packet count
// Revision    : 1.0 - initial release
// ============================================================================
module link_sensores_arq
    import sensores_pkg::*;
#(
    parameter  int N_CANAIS     = 8,
    parameter  int LARGURA      = 8,
    parameter  int MAX_REENVIOS = 3,
    localparam int A            = bits_endereco(N_CANAIS),
    localparam int P            = largura_pacote(A, LARGURA)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CANAIS*LARGURA-1:0]   sensores,
    input  logic                          habilita,
    input  logic                          erro_injetado,
    output logic [P-1:0]                  pacote,
    output logic                          pacote_valido,
    output logic                          solicitar_reenvio,
    output logic [N_CANAIS*LARGURA-1:0]   saidas,
    output logic [N_CANAIS-1:0]           atualizado,
    output logic [A-1:0]                  canal_ativo,
    output logic [LARGURA_FALHAS-1:0]     falhas
);

    localparam int            LSB_END      = lsb_endereco(LARGURA);
    localparam int            POS_PAR      = pos_paridade(A, LARGURA);
    localparam logic [A-1:0]  ULTIMO_CANAL = A'(N_CANAIS - 1);

    estado_t              estado;
    logic [P-1:0]         enlace;          // receive-side link register
    logic                 erro_enlace;
    logic [A-1:0]         endereco_enlace;
    logic [LARGURA-1:0]   dado_enlace;
    logic [LARGURA-1:0]   amostra;
    logic [A-1:0]         proximo_canal;
    logic                 verifica_ok;

    verificador_paridade_param #(
        .P (P)
    ) u_verificador (
        .pacote (enlace),
        .erro   (erro_enlace)
    );

    assign endereco_enlace = enlace[LSB_END +: A];
    assign dado_enlace     = enlace[LARGURA-1:0];
    assign amostra         = sensores[int'(canal_ativo) * LARGURA +: LARGURA];
    assign proximo_canal   = (canal_ativo == ULTIMO_CANAL) ? '0 : canal_ativo + 1'b1;
    assign verifica_ok     = (estado == VERIFICA) && !erro_enlace;
    assign pacote_valido   = (estado == ENVIA);

    // Write strobe coincides with the VERIFICA cycle; the bank itself
    // updates on the edge that closes that cycle.
    always_comb begin
        atualizado = '0;
        for (int k = 0; k < N_CANAIS; k++) begin
            atualizado[k] = verifica_ok && (endereco_enlace == A'(k));
        end
    end

`ifdef SENSORES_RETX_EN
    logic [3:0] tentativa;

    assign solicitar_reenvio = (estado == VERIFICA) && erro_enlace;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            canal_ativo <= '0;
            tentativa   <= '0;
            pacote      <= '0;
            enlace      <= '0;
            saidas      <= '0;
            falhas      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (habilita) begin
                        pacote    <= {^{canal_ativo, amostra}, canal_ativo, amostra};
                        tentativa <= '0;
                        estado    <= ENVIA;
                    end
                end
                ENVIA: begin
                    enlace <= pacote ^ {{(P-1){1'b0}}, erro_injetado};
                    estado <= VERIFICA;
                end
                VERIFICA: begin
                    if (!erro_enlace) begin
                        for (int k = 0; k < N_CANAIS; k++) begin
                            if (endereco_enlace == A'(k)) begin
                                saidas[k*LARGURA +: LARGURA] <= dado_enlace;
                            end
                        end
                        canal_ativo <= proximo_canal;
                        estado      <= OCIOSO;
                    end else if (tentativa < 4'(MAX_REENVIOS)) begin
                        // Resend the same latched packet; never resample.
                        tentativa <= tentativa + 4'd1;
                        estado    <= ENVIA;
                    end else begin
                        if (falhas != FALHAS_SATURADO) begin
                            falhas <= falhas + 1'b1;
                        end
                        canal_ativo <= proximo_canal;
                        estado      <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
`else
    assign solicitar_reenvio = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= OCIOSO;
            canal_ativo <= '0;
            pacote      <= '0;
            enlace      <= '0;
            saidas      <= '0;
            falhas      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (habilita) begin
                        pacote <= {^{canal_ativo, amostra}, canal_ativo, amostra};
                        estado <= ENVIA;
                    end
                end
                ENVIA: begin
                    enlace <= pacote ^ {{(P-1){1'b0}}, erro_injetado};
                    estado <= VERIFICA;
                end
                VERIFICA: begin
                    if (!erro_enlace) begin
                        for (int k = 0; k < N_CANAIS; k++) begin
                            if (endereco_enlace == A'(k)) begin
                                saidas[k*LARGURA +: LARGURA] <= dado_enlace;
                            end
                        end
                    end else if (falhas != FALHAS_SATURADO) begin
                        falhas <= falhas + 1'b1;
                    end
                    canal_ativo <= proximo_canal;
                    estado      <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
`endif

    // Parity bit position is implied by the packet layout; kept for clarity.
    if (POS_PAR != P - 1) begin : g_layout_check
        $error("packet layout mismatch");
    end

endmodule
`default_nettype wire

// File: tb/tb_link_sensores_arq.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_sensores_arq
// Description : Self-checking bench for link_sensores_arq (N=8 and N=5
//               instances). Works with or without SENSORES_RETX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_sensores_arq;

`ifdef SENSORES_RETX_EN
    localparam bit RETX      = 1'b1;
    localparam int CICLOS    = 9;   // 1 + 2*(MAX_REENVIOS+1)
    localparam int EXP_PULSO = 4;
`else
    localparam bit RETX      = 1'b0;
    localparam int CICLOS    = 3;
    localparam int EXP_PULSO = 0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] sensores;
    logic        habilita;
    logic        erro_injetado;
    logic [11:0] pacote;
    logic        pacote_valido;
    logic        solicitar_reenvio;
    logic [63:0] saidas;
    logic [7:0]  atualizado;
    logic [2:0]  canal_ativo;
    logic [7:0]  falhas;

    logic [39:0] sensores5;
    logic        habilita5;
    logic        erro5;
    logic [11:0] pacote5;
    logic        valido5;
    logic        solicitar5;
    logic [39:0] saidas5;
    logic [4:0]  atualizado5;
    logic [2:0]  canal5;
    logic [7:0]  falhas5;

    int errors = 0;
    int checks = 0;
    logic [7:0] modelo [8];

    link_sensores_arq #(.N_CANAIS(8), .LARGURA(8), .MAX_REENVIOS(3)) dut (
        .clk(clk), .rst(rst), .sensores(sensores), .habilita(habilita),
        .erro_injetado(erro_injetado), .pacote(pacote), .pacote_valido(pacote_valido),
        .solicitar_reenvio(solicitar_reenvio), .saidas(saidas), .atualizado(atualizado),
        .canal_ativo(canal_ativo), .falhas(falhas)
    );

    link_sensores_arq #(.N_CANAIS(5), .LARGURA(8), .MAX_REENVIOS(3)) dut5 (
        .clk(clk), .rst(rst), .sensores(sensores5), .habilita(habilita5),
        .erro_injetado(erro5), .pacote(pacote5), .pacote_valido(valido5),
        .solicitar_reenvio(solicitar5), .saidas(saidas5), .atualizado(atualizado5),
        .canal_ativo(canal5), .falhas(falhas5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  canal;
        logic [7:0]  dado;
        logic [7:0]  onehot;
        logic [11:0] pac;
    } vetor_t;

    typedef struct {
        logic [2:0]  canal;
        logic [4:0]  onehot;
        logic [11:0] pac;
    } vetor5_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] modelo_plano();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = modelo[k];
        return r;
    endfunction

    task automatic clean_packet(input int k);
        habilita = 1'b1;
        step();
        habilita = 1'b0;   // dropping habilita must not abort
        step();
        step();
        modelo[k] = sensores[k*8 +: 8];
    endtask

    vetor_t  tab  [9];
    vetor5_t tab5 [6];
    int pulsos;
    int ups;

    initial begin
        tab[0] = '{3'd0, 8'h10, 8'h01, 12'h810};
        tab[1] = '{3'd1, 8'h11, 8'h02, 12'h911};
        tab[2] = '{3'd2, 8'h12, 8'h04, 12'hA12};
        tab[3] = '{3'd3, 8'h13, 8'h08, 12'hB13};
        tab[4] = '{3'd4, 8'h14, 8'h10, 12'hC14};
        tab[5] = '{3'd5, 8'h15, 8'h20, 12'hD15};
        tab[6] = '{3'd6, 8'h16, 8'h40, 12'hE16};
        tab[7] = '{3'd7, 8'h17, 8'h80, 12'hF17};
        tab[8] = '{3'd0, 8'h10, 8'h01, 12'h810};

        tab5[0] = '{3'd0, 5'h01, 12'h030};
        tab5[1] = '{3'd1, 5'h02, 12'h131};
        tab5[2] = '{3'd2, 5'h04, 12'h232};
        tab5[3] = '{3'd3, 5'h08, 12'h333};
        tab5[4] = '{3'd4, 5'h10, 12'h434};
        tab5[5] = '{3'd0, 5'h01, 12'h030};

        rst = 1'b1; habilita = 1'b0; erro_injetado = 1'b0;
        habilita5 = 1'b0; erro5 = 1'b0;
        for (int k = 0; k < 8; k++) sensores[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++) sensores5[k*8 +: 8] = 8'h30 + 8'(k);
        for (int k = 0; k < 8; k++) modelo[k] = 8'h00;
        step(); step();

        // Reset state
        chk("rst_pacote", 64'(pacote), 64'h0);
        chk("rst_valido", 64'(pacote_valido), 64'h0);
        chk("rst_solicitar", 64'(solicitar_reenvio), 64'h0);
        chk("rst_saidas", saidas, 64'h0);
        chk("rst_atualizado", 64'(atualizado), 64'h0);
        chk("rst_canal", 64'(canal_ativo), 64'h0);
        chk("rst_falhas", 64'(falhas), 64'h0);
        rst = 1'b0;

        // Back-to-back clean packets, 3 cycles each
        habilita = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t1_valido", 64'(pacote_valido), 64'h1);
            chk("t1_canal", 64'(canal_ativo), 64'(tab[i].canal));
            chk("t1_pacote", 64'(pacote), 64'(tab[i].pac));
            step();
            chk("t1_atualizado", 64'(atualizado), 64'(tab[i].onehot));
            chk("t1_solicitar", 64'(solicitar_reenvio), 64'h0);
            if (i == 8) habilita = 1'b0;
            step();
            chk("t1_saida", 64'(saidas[int'(tab[i].canal)*8 +: 8]), 64'(tab[i].dado));
            chk("t1_atual_off", 64'(atualizado), 64'h0);
        end
        chk("t1_saidas_all", saidas, 64'h1716151413121110);
        chk("t1_falhas", 64'(falhas), 64'h0);
        chk("t1_canal_fim", 64'(canal_ativo), 64'h1);

        // Single injected error on the first send of channel 3
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 8; k++) modelo[k] = 8'h00;
        sensores[3*8 +: 8] = 8'hA5;
        clean_packet(0); clean_packet(1); clean_packet(2);
        habilita = 1'b1; erro_injetado = 1'b1;
        step();
        chk("t2_valido", 64'(pacote_valido), 64'h1);
        chk("t2_pacote", 64'(pacote), 64'h3A5);
        habilita = 1'b0;
        sensores[3*8 +: 8] = 8'h00;   // must not affect the in-flight packet
        step();
        chk("t2_solicitar", 64'(solicitar_reenvio), 64'(RETX));
        chk("t2_atual_bad", 64'(atualizado), 64'h0);
        erro_injetado = 1'b0;
        if (RETX) begin
            step();
            chk("t2_resend_valido", 64'(pacote_valido), 64'h1);
            chk("t2_resend_pacote", 64'(pacote), 64'h3A5);
            step();
            chk("t2_solicitar2", 64'(solicitar_reenvio), 64'h0);
            chk("t2_atualizado", 64'(atualizado), 64'h08);
            step();
            modelo[3] = 8'hA5;
            chk("t2_saida3", 64'(saidas[31:24]), 64'hA5);
            chk("t2_falhas", 64'(falhas), 64'h0);
        end else begin
            step();
            chk("t2_falhas", 64'(falhas), 64'h1);
            chk("t2_valido_off", 64'(pacote_valido), 64'h0);
        end
        chk("t2_canal", 64'(canal_ativo), 64'h4);
        chk("t2_saidas", saidas, modelo_plano());

        // Error held high: retries exhausted, packet dropped
        sensores[3*8 +: 8] = 8'hA5;
        habilita = 1'b1; erro_injetado = 1'b1;
        step();
        habilita = 1'b0;
        pulsos = 0; ups = 0;
        for (int c = 0; c < CICLOS - 1; c++) begin
            pulsos += int'(solicitar_reenvio);
            ups    += int'(|atualizado);
            if (solicitar_reenvio && (|atualizado)) begin
                checks++; errors++;
                $display("FAIL t3_overlap: solicitar and atualizado both high");
            end
            step();
        end
        chk("t3_pulsos", 64'(pulsos), 64'(EXP_PULSO));
        chk("t3_ups", 64'(ups), 64'h0);
        chk("t3_falhas", 64'(falhas), RETX ? 64'h1 : 64'h2);
        chk("t3_canal", 64'(canal_ativo), 64'h5);
        chk("t3_saidas", saidas, modelo_plano());

        // Saturation of the failure counter
        habilita = 1'b1;
        repeat (3000) step();
        habilita = 1'b0;
        repeat (12) step();
        chk("t3_saturado", 64'(falhas), 64'd255);
        chk("t3_saidas_sat", saidas, modelo_plano());
        erro_injetado = 1'b0;

        // Non-power-of-two channel count
        habilita5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_canal", 64'(canal5), 64'(tab5[i].canal));
            chk("t4_pacote", 64'(pacote5), 64'(tab5[i].pac));
            step();
            chk("t4_atualizado", 64'(atualizado5), 64'(tab5[i].onehot));
            if (i == 5) habilita5 = 1'b0;
            step();
        end
        chk("t4_canal_fim", 64'(canal5), 64'h1);
        chk("t4_saidas", 64'(saidas5), 64'h3433323130);

        // Reset during VERIFICA of a bad packet
        rst = 1'b1; step(); rst = 1'b0;
        habilita = 1'b1; erro_injetado = 1'b1;
        step();
        habilita = 1'b0;
        step();
        chk("t5_solicitar", 64'(solicitar_reenvio), 64'(RETX));
        rst = 1'b1;
        step();
        chk("t5_pacote", 64'(pacote), 64'h0);
        chk("t5_valido", 64'(pacote_valido), 64'h0);
        chk("t5_solicitar_rst", 64'(solicitar_reenvio), 64'h0);
        chk("t5_saidas", saidas, 64'h0);
        chk("t5_atualizado", 64'(atualizado), 64'h0);
        chk("t5_canal", 64'(canal_ativo), 64'h0);
        chk("t5_falhas", 64'(falhas), 64'h0);
        rst = 1'b0; erro_injetado = 1'b0;
        step(); step();
        chk("t5_falhas_pos", 64'(falhas), 64'h0);
        chk("t5_valido_pos", 64'(pacote_valido), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
